// File: rtl/evrisim_pkg.sv
// Shared definitions for the evrisim SRAM arbiter slice.
// Holds the default SRAM geometry (word width, address width, valid depth)
// and the controller state encoding used by evrisim_sram_arbiter.
package evrisim_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 11;
    localparam int unsigned ADDR_WIDTH_DEF = 9;
    localparam int unsigned DEPTH_DEF      = 320;

    // INIT clears the whole valid range; RUN serves requests until reset.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   req           : request vector (bit n = reader n)
//   update        : a granted request completed; remember who won
//   grant         : one-hot grant or zero, purely combinational from req
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Index of the reader granted last; reset to 1 so reader 0 wins the first tie.
    logic last_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            last_q <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/evrisim_sram_arbiter.sv
// Arbiter in front of a 1W/1R SRAM macro: one writer, two round-robin readers.
// After reset the whole valid range is cleared to zero, then requests are served.
//   clk_i, rstn_i                    : clock, synchronous active-low reset
//   wr_valid_i/wr_ready_o/addr/data  : writer request
//   rd_valid_i/rd_ready_o, rd0/rd1   : reader requests (bit n = reader n)
//   rsp_valid_o/id/err/data          : read response, one cycle after handshake
//   sram_csb0_o/addr0/din0           : macro write port (csb active-low)
//   sram_csb1_o/addr1, sram_dout1_i  : macro read port (csb active-low)
//   init_done_o                      : clear sequence finished
module evrisim_sram_arbiter
    import evrisim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,

    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,

    input  logic [1:0]            rd_valid_i,
    output logic [1:0]            rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd0_addr_i,
    input  logic [ADDR_WIDTH-1:0] rd1_addr_i,

    output logic                  rsp_valid_o,
    output logic                  rsp_id_o,
    output logic                  rsp_err_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,

    output logic                  sram_csb0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [DATA_WIDTH-1:0] sram_din0_o,

    output logic                  sram_csb1_o,
    output logic [ADDR_WIDTH-1:0] sram_addr1_o,
    input  logic [DATA_WIDTH-1:0] sram_dout1_i,

    output logic                  init_done_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;

    logic                  rsp_valid_q;
    logic                  rsp_id_q;
    logic                  rsp_err_q;

    logic [1:0]            grant;
    logic                  win_id;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  collide;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  wr_in_range;
    logic                  rd_in_range;

    rr_arbiter2 u_rr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req    (rd_valid_i),
        .update (rd_fire),
        .grant  (grant)
    );

    assign win_id      = grant[1];
    assign win_addr    = grant[1] ? rd1_addr_i : rd0_addr_i;
    assign wr_in_range = 32'(wr_addr_i) < DEPTH;
    assign rd_in_range = 32'(win_addr) < DEPTH;

    // A write to the address the winning reader wants goes first; the read is
    // held off one cycle so it is re-arbitrated and sees the new data.
    assign collide = wr_valid_i && (grant != 2'b00) && (win_addr == wr_addr_i);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ready_o   = 1'b0;
        rd_ready_o   = 2'b00;
        wr_fire      = 1'b0;
        rd_fire      = 1'b0;
        sram_csb0_o  = 1'b1;
        sram_addr0_o = '0;
        sram_din0_o  = '0;
        sram_csb1_o  = 1'b1;
        sram_addr1_o = '0;

        case (state_q)
            ST_INIT: begin
                sram_csb0_o  = 1'b0;
                sram_addr0_o = clr_cnt_q;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_ready_o = 1'b1;
                wr_fire    = wr_valid_i;
                if (wr_fire && wr_in_range) begin
                    sram_csb0_o  = 1'b0;
                    sram_addr0_o = wr_addr_i;
                    sram_din0_o  = wr_data_i;
                end
                if (!collide) begin
                    rd_ready_o = grant;
                end
                rd_fire = (rd_valid_i & rd_ready_o) != 2'b00;
                if (rd_fire && rd_in_range) begin
                    sram_csb1_o  = 1'b0;
                    sram_addr1_o = win_addr;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (state_q == ST_INIT) begin
                clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
            end
            rsp_valid_q <= rd_fire;
            rsp_err_q   <= rd_fire && !rd_in_range;
            if (rd_fire) begin
                rsp_id_q <= win_id;
            end
        end
    end

    // Read data comes straight from the macro in the response cycle; it is
    // masked to zero whenever no good response is being presented.
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_err_o   = rsp_valid_q && rsp_err_q;
    assign rsp_data_o  = (rsp_valid_q && !rsp_err_q) ? sram_dout1_i : '0;
    assign init_done_o = (state_q == ST_RUN);

endmodule
